// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the 1-to-N handshake demultiplexer.
package dmux_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_AUTO = 1'b1;

    localparam int STATS_W = 16;

    // Wraps modulo n_ch exactly, so non-power-of-two channel counts work.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned n_ch);
        return (ptr == n_ch - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dmux_ch_buf.sv
// One-entry output holding register for a single demux channel.
// A fill on the same edge as a drain keeps the entry full, giving one word per cycle.
module dmux_ch_buf
    import dmux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              out_ready,
    output logic              can_fill,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    // Empty, or the held word leaves on this very edge.
    assign can_fill = !out_valid || out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the data register is reset as well because the block exposes out_data = 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (fill) begin
                out_valid <= 1'b1;
                out_data  <= fill_data;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmux_1ton_hs.sv
// Registered 1-to-N demultiplexer with valid/ready on input and every output channel.
// Optional transfer counter enabled by defining DMUX_STATS_EN.
module dmux_1ton_hs
    import dmux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic                     sel_err
`ifdef DMUX_STATS_EN
    ,
    output logic [STATS_W-1:0]       xfer_cnt
`endif
);

    localparam int              SEL_SPAN = 1 << SEL_W;
    localparam logic [SEL_W:0]  N_CH_L   = (SEL_W + 1)'(N_CH);

    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    tgt;
    logic                in_range;
    logic                accept;
    logic [N_CH-1:0]     fill;
    logic [N_CH-1:0]     can_fill;
    logic [SEL_SPAN-1:0] can_fill_ext;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        tgt          = (mode == MODE_AUTO) ? ptr : in_sel;
        in_range     = {1'b0, tgt} < N_CH_L;
        can_fill_ext = '0;
        can_fill_ext[N_CH-1:0] = can_fill;
        // Out-of-range words are swallowed rather than stalling the producer.
        in_ready     = in_range ? can_fill_ext[tgt] : 1'b1;
        accept       = in_valid && in_ready;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign fill[k] = accept && in_range && (tgt == SEL_W'(k));

        dmux_ch_buf #(
            .DATA_W (DATA_W)
        ) u_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .fill      (fill[k]),
            .fill_data (in_data),
            .out_ready (out_ready[k]),
            .can_fill  (can_fill[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W])
        );
    end

    // The pointer never skips a full channel, which keeps auto-mode delivery strictly ordered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= '0;
            sel_err <= 1'b0;
        end else begin
            if (accept && mode == MODE_AUTO) begin
                ptr <= SEL_W'(ptr_wrap_inc(32'(ptr), 32'(N_CH)));
            end
            if (accept && !in_range) begin
                sel_err <= 1'b1;
            end
        end
    end

`ifdef DMUX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (accept && in_range) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmux_1ton_hs.sv
// Scoreboard bench for dmux_1ton_hs with three channels (non-power-of-two wrap).
// Build with DMUX_STATS_EN defined to also check the transfer counter.
module tb_dmux_1ton_hs;
    import dmux_pkg::*;

    localparam int DATA_W = 8;
    localparam int N_CH   = 3;
    localparam int SEL_W  = $clog2(N_CH);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic [SEL_W-1:0]       in_sel;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ready;
    logic [N_CH*DATA_W-1:0] out_data;
    logic                   sel_err;
`ifdef DMUX_STATS_EN
    logic [STATS_W-1:0]     xfer_cnt;
`endif

    always #5 clk = ~clk;

    dmux_1ton_hs #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err)
`ifdef DMUX_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one queue per channel holds the word expected in its buffer.
    logic [DATA_W-1:0] sbq [N_CH][$];
    int                mptr;
    logic              merr;
    int                mcnt;

    always @(negedge clk) begin : mon
        int   t;
        logic rng;
        logic exp_rdy;
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) sbq[k].delete();
            mptr = 0;
            merr = 1'b0;
            mcnt = 0;
        end else begin
            t       = (mode == MODE_AUTO) ? mptr : int'(in_sel);
            rng     = t < N_CH;
            exp_rdy = rng ? (sbq[t].size() == 0 || out_ready[t]) : 1'b1;
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("sel_err", 32'(sel_err), 32'(merr));
`ifdef DMUX_STATS_EN
            check("xfer_cnt", 32'(xfer_cnt), 32'(mcnt[STATS_W-1:0]));
`endif
            for (int k = 0; k < N_CH; k++) begin
                check($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(sbq[k].size() != 0));
                if (sbq[k].size() != 0) begin
                    check($sformatf("out_data%0d", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(sbq[k][0]));
                    if (out_ready[k]) void'(sbq[k].pop_front());
                end
            end
            if (in_valid && in_ready) begin
                if (rng) begin
                    sbq[t].push_back(in_data);
                    mcnt++;
                end else begin
                    merr = 1'b1;
                end
                if (mode == MODE_AUTO) mptr = (mptr == N_CH - 1) ? 0 : mptr + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        check({"accept_", tag}, 32'(got), 32'd1);
    endtask

    task automatic send(input logic m, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d, input string tag);
        mode     = m;
        in_sel   = s;
        in_data  = d;
        in_valid = 1'b1;
        wait_accept(tag);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        mode      = MODE_ADDR;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Addressed sweep
        out_ready = '1;
        for (int i = 0; i < N_CH; i++) send(MODE_ADDR, SEL_W'(i), 8'hA0 + 8'(i), "sweep");
        idle(2);

        // Back-pressure on channel 2, then release with pass-through
        out_ready = 3'b011;
        send(MODE_ADDR, 2'd2, 8'h11, "bp_first");
        in_data = 8'h22;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall", 32'(in_ready), 32'd0);
            check("bp_hold", 32'(out_data[2*DATA_W +: DATA_W]), 32'h11);
        end
        @(posedge clk);
        #1;
        out_ready = '1;
        wait_accept("bp_release");
        in_valid = 1'b0;
        check("bp_pass_valid", 32'(out_valid), 32'b100);
        check("bp_pass_data", 32'(out_data[2*DATA_W +: DATA_W]), 32'h22);
        idle(2);

        // Auto-mode wrap: words 1..7 land on 0,1,2,0,1,2,0, leaving ptr at 1
        for (int i = 1; i <= 7; i++) send(MODE_AUTO, 2'd0, 8'(i), "auto");
        send(MODE_AUTO, 2'd0, 8'h08, "auto_ptr1");
        check("auto_ptr1_valid", 32'(out_valid), 32'b010);
        check("auto_ptr1_data", 32'(out_data[1*DATA_W +: DATA_W]), 32'h08);
        // Addressed traffic must not move the pointer
        send(MODE_ADDR, 2'd0, 8'h09, "mode_sw_addr");
        send(MODE_AUTO, 2'd0, 8'h0A, "mode_sw_auto");
        check("mode_sw_valid", 32'(out_valid), 32'b100);
        idle(2);

        // Out-of-range select is dropped and latches sel_err
        send(MODE_ADDR, 2'd3, 8'h55, "oor");
        in_valid = 1'b0;
        check("oor_no_valid", 32'(out_valid), 32'd0);
        check("oor_sel_err", 32'(sel_err), 32'd1);
        for (int i = 0; i < 10; i++) send(MODE_ADDR, SEL_W'(i % N_CH), 8'h60 + 8'(i), "post_oor");
        idle(2);
        check("oor_sticky", 32'(sel_err), 32'd1);

        // Reset mid-operation with all channels full
        out_ready = '0;
        for (int i = 0; i < N_CH; i++) send(MODE_ADDR, SEL_W'(i), 8'hC0 + 8'(i), "fill");
        in_valid = 1'b0;
        check("full_valid", 32'(out_valid), 32'b111);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_sel_err", 32'(sel_err), 32'd0);
        out_ready = '1;
        send(MODE_AUTO, 2'd0, 8'h77, "mid_rst_ptr");
        check("mid_rst_ptr0", 32'(out_valid), 32'b001);
        idle(2);

        // Random traffic and back-pressure against the scoreboard
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            mode      = 1'($urandom_range(0, 1));
            in_sel    = SEL_W'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = N_CH'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = '1;
        idle(3);
        for (int k = 0; k < N_CH; k++) check($sformatf("drained%0d", k), 32'(sbq[k].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
